// File: rtl/maxpool_scheduler.sv
// Drives a serial max-pool unit across one feature map: streams each KxK window
// from the feature buffer, waits for the pooled result and writes it to the output buffer.
module maxpool_scheduler #(
    parameter int BITS    = 8,
    parameter int POOL_K  = 2,
    parameter int FM_W    = 8,
    parameter int FM_H    = 8,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               go,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [BITS-1:0]    rd_data,
    output logic               mp_rst_n,
    output logic               mp_start,
    output logic [BITS-1:0]    mp_data_in,
    input  logic [BITS-1:0]    mp_data_out,
    input  logic               mp_ready,
    input  logic               out_full,
    output logic               wr_en,
    output logic [OADDR_W-1:0] wr_addr,
    output logic [BITS-1:0]    wr_data
);

    localparam int WIN_X = FM_W / POOL_K;
    localparam int WIN_Y = FM_H / POOL_K;
    localparam int K_W   = $clog2(POOL_K);
    localparam int WX_W  = (WIN_X > 1) ? $clog2(WIN_X) : 1;
    localparam int WY_W  = (WIN_Y > 1) ? $clog2(WIN_Y) : 1;

    localparam logic [K_W-1:0]  K_LAST  = K_W'(POOL_K - 1);
    localparam logic [WX_W-1:0] WX_LAST = WX_W'(WIN_X - 1);
    localparam logic [WY_W-1:0] WY_LAST = WY_W'(WIN_Y - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      dx_q, dx_d;
    logic [K_W-1:0]      dy_q, dy_d;
    logic [WX_W-1:0]     wx_q, wx_d;
    logic [WY_W-1:0]     wy_q, wy_d;
    logic [OADDR_W-1:0]  widx_q, widx_d;
    logic [BITS-1:0]     wr_data_q, wr_data_d;
    logic                mp_start_q, mp_start_d;
    logic                abort_q, abort_d;
    logic                last_win;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dx_q       <= '0;
            dy_q       <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            widx_q     <= '0;
            wr_data_q  <= '0;
            mp_start_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            widx_q     <= widx_d;
            wr_data_q  <= wr_data_d;
            mp_start_q <= mp_start_d;
            abort_q    <= abort_d;
        end
    end

    assign last_win = (wx_q == WX_LAST) && (wy_q == WY_LAST);

    always_comb begin
        state_d    = state_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        widx_d     = widx_q;
        wr_data_d  = wr_data_q;
        mp_start_d = 1'b0;
        abort_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // mp_start lands one cycle later, together with the first sample's read data
                mp_start_d = (dx_q == '0) && (dy_q == '0);
                if (dx_q == K_LAST) begin
                    dx_d = '0;
                    if (dy_q == K_LAST) begin
                        dy_d    = '0;
                        state_d = S_WAIT;
                    end else begin
                        dy_d = dy_q + K_W'(1);
                    end
                end else begin
                    dx_d = dx_q + K_W'(1);
                end
            end
            S_WAIT: begin
                if (mp_ready) begin
                    wr_data_d = mp_data_out;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    if (last_win) begin
                        wx_d    = '0;
                        wy_d    = '0;
                        widx_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        widx_d  = widx_q + OADDR_W'(1);
                        state_d = S_READ;
                        if (wx_q == WX_LAST) begin
                            wx_d = '0;
                            wy_d = wy_q + WY_W'(1);
                        end else begin
                            wx_d = wx_q + WX_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort also wins over go in IDLE; only a live map gets a pool-unit reset pulse
        if (abort) begin
            state_d    = S_IDLE;
            dx_d       = '0;
            dy_d       = '0;
            wx_d       = '0;
            wy_d       = '0;
            widx_d     = '0;
            mp_start_d = 1'b0;
            abort_d    = (state_q != S_IDLE);
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign rd_en      = (state_q == S_READ) && !abort;
    assign wr_en      = (state_q == S_WRITE) && !abort;
    assign mp_start   = mp_start_q && !abort;
    assign mp_rst_n   = rst_n & ~abort_q;
    assign mp_data_in = rd_data;
    assign wr_addr    = widx_q;
    assign wr_data    = wr_data_q;

    assign rd_addr = ADDR_W'(wy_q) * ADDR_W'(POOL_K * FM_W)
                   + ADDR_W'(wx_q) * ADDR_W'(POOL_K)
                   + ADDR_W'(dy_q) * ADDR_W'(FM_W)
                   + ADDR_W'(dx_q);

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Directed bench for maxpool_scheduler on a 4x4 map with 2x2 windows, using
// behavioural models of the feature buffer and the serial pool unit.
module tb_maxpool_scheduler;

    localparam int BITS = 8;
    localparam int K    = 2;
    localparam int FW   = 4;
    localparam int FH   = 4;
    localparam int AW   = 4;
    localparam int OW   = 2;
    localparam int N    = K * K;

    logic            clk_in = 1'b0;
    logic            rst_n = 1'b1;
    logic            go = 1'b0;
    logic            abort = 1'b0;
    logic            out_full = 1'b0;
    logic            busy, done, rd_en, mp_rst_n, mp_start, wr_en;
    logic [AW-1:0]   rd_addr;
    logic [BITS-1:0] rd_data;
    logic [BITS-1:0] mp_data_in, mp_data_out;
    logic            mp_ready;
    logic [OW-1:0]   wr_addr;
    logic [BITS-1:0] wr_data;

    always #5 clk_in = ~clk_in;

    maxpool_scheduler #(
        .BITS(BITS), .POOL_K(K), .FM_W(FW), .FM_H(FH), .ADDR_W(AW), .OADDR_W(OW)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .go(go), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .mp_rst_n(mp_rst_n), .mp_start(mp_start), .mp_data_in(mp_data_in),
        .mp_data_out(mp_data_out), .mp_ready(mp_ready), .out_full(out_full),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Feature buffer: one-cycle read latency
    logic [BITS-1:0] mem [16];
    always @(posedge clk_in) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Serial pool unit: start carries the first sample, ready rises after sample N
    int              pm_cnt;
    logic [BITS-1:0] pm_max;
    always @(posedge clk_in or negedge mp_rst_n) begin
        if (!mp_rst_n) begin
            pm_cnt   <= 0;
            pm_max   <= '0;
            mp_ready <= 1'b1;
        end else if (mp_start) begin
            pm_max   <= mp_data_in;
            pm_cnt   <= 1;
            mp_ready <= 1'b0;
        end else if (pm_cnt != 0) begin
            if (mp_data_in > pm_max) pm_max <= mp_data_in;
            if (pm_cnt == N - 1) begin
                pm_cnt   <= 0;
                mp_ready <= 1'b1;
            end else begin
                pm_cnt <= pm_cnt + 1;
            end
        end
    end
    assign mp_data_out = pm_max;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int           go_cyc;
    int           done_cnt, done_rel, wr_en_cnt, hold_cnt, mprst_cnt, stray;
    logic [OW-1:0]   wa_q [$];
    logic [BITS-1:0] wd_q [$];
    logic [AW-1:0]   ra_q [$];

    // Everything the checks need is captured mid-cycle, well away from the active edge
    always @(negedge clk_in) begin
        if (wr_en) wr_en_cnt++;
        if (wr_en && wr_addr == 2'd1 && wr_data == 8'd7) hold_cnt++;
        if (wr_en && !out_full) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (rd_en) ra_q.push_back(rd_addr);
        if (done) begin
            done_cnt++;
            done_rel = cyc - go_cyc;
        end
        if (rst_n && !mp_rst_n) mprst_cnt++;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic loadMap(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       mem[i] = 8'(i);
                1:       mem[i] = (i == 0 || i == 3 || i == 9 || i == 14) ? 8'h00 : 8'hFF;
                default: mem[i] = 8'h00;
            endcase
        end
    endtask

    task automatic checkAsyncReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_mp_start", mp_start, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_mp_rst_n", mp_rst_n, 0);
    endtask

    // One go at cycle 0, then per-cycle backpressure / abort / extra go / reset events
    task automatic applyStimulus(input int mode, input int ncyc, input int full_from,
                                 input int full_len, input int abort_at, input int rst_at,
                                 input logic [63:0] go_mask);
        loadMap(mode);
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        done_cnt  = 0;
        done_rel  = -1;
        wr_en_cnt = 0;
        hold_cnt  = 0;
        mprst_cnt = 0;
        stray     = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_in);
            #1;
            if (c == 0) go_cyc = cyc;
            go       = (c == 0) || go_mask[c];
            abort    = (c == abort_at);
            out_full = (c >= full_from) && (c < full_from + full_len);
            if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
            if (rst_at >= 0 && c > rst_at + 2 && busy) stray++;
            if (abort_at >= 0 && c == abort_at) begin
                #1;
                checkOutput("abort_rd_en", rd_en, 0);
                checkOutput("abort_mp_start", mp_start, 0);
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                checkOutput("abort_idle", busy, 0);
                checkOutput("abort_mp_rst_n", mp_rst_n, 0);
            end
            if (rst_at >= 0 && c == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkAsyncReset();
            end
        end
        go       = 1'b0;
        abort    = 1'b0;
        out_full = 1'b0;
    endtask

    task automatic checkWrites(input string tag, input int n, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        checkOutput({tag, "_count"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            checkOutput($sformatf("%s_data%0d", tag, i), wd_q[i], e[i]);
        end
    endtask

    task automatic checkReads(input string tag, input int n);
        logic [3:0] rexp [16];
        rexp = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd2, 4'd3, 4'd6, 4'd7,
                 4'd8, 4'd9, 4'd12, 4'd13, 4'd10, 4'd11, 4'd14, 4'd15};
        checkOutput({tag, "_rd_count"}, ra_q.size(), n);
        for (int i = 0; i < n && i < ra_q.size(); i++) begin
            checkOutput($sformatf("%s_rd%0d", tag, i), ra_q[i], rexp[i]);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checkAsyncReset();
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("post_rst_mp_rst_n", mp_rst_n, 1);
        checkOutput("post_rst_busy", busy, 0);

        $display("[TB] basic map, address-valued data");
        applyStimulus(0, 40, 100, 0, -1, -1, 64'h0);
        checkWrites("basic", 4, 8'd5, 8'd7, 8'd13, 8'd15);
        checkReads("basic", 16);
        checkOutput("basic_done_cnt", done_cnt, 1);
        checkOutput("basic_done_cycle", done_rel, 29);
        checkOutput("basic_wr_en_cycles", wr_en_cnt, 4);
        checkOutput("basic_idle_after", busy, 0);

        $display("[TB] backpressure on window 1");
        applyStimulus(0, 45, 14, 5, -1, -1, 64'h0);
        checkWrites("bp", 4, 8'd5, 8'd7, 8'd13, 8'd15);
        checkOutput("bp_hold_cycles", hold_cnt, 6);
        checkOutput("bp_wr_en_cycles", wr_en_cnt, 9);
        checkOutput("bp_done_cycle", done_rel, 34);

        $display("[TB] abort in window 2");
        applyStimulus(0, 30, 100, 0, 16, -1, 64'h0);
        checkWrites("abort", 2, 8'd5, 8'd7, 8'd0, 8'd0);
        checkReads("abort", 9);
        checkOutput("abort_done_cnt", done_cnt, 0);
        checkOutput("abort_mprst_cycles", mprst_cnt, 1);
        applyStimulus(0, 40, 100, 0, -1, -1, 64'h0);
        checkWrites("rerun", 4, 8'd5, 8'd7, 8'd13, 8'd15);
        checkOutput("rerun_done_cycle", done_rel, 29);

        $display("[TB] go pulses while busy");
        applyStimulus(0, 45, 100, 0, -1, -1, 64'h40A4);
        checkWrites("gobusy", 4, 8'd5, 8'd7, 8'd13, 8'd15);
        checkOutput("gobusy_done_cnt", done_cnt, 1);
        checkOutput("gobusy_done_cycle", done_rel, 29);

        $display("[TB] extreme data patterns");
        applyStimulus(1, 40, 100, 0, -1, -1, 64'h0);
        checkWrites("ff", 4, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(2, 40, 100, 0, -1, -1, 64'h0);
        checkWrites("zero", 4, 8'h00, 8'h00, 8'h00, 8'h00);

        $display("[TB] async reset mid-wait");
        applyStimulus(0, 40, 100, 0, -1, 12, 64'h0);
        checkWrites("arst", 1, 8'd5, 8'd0, 8'd0, 8'd0);
        checkOutput("arst_done_cnt", done_cnt, 0);
        checkOutput("arst_stray_busy", stray, 0);
        applyStimulus(0, 40, 100, 0, -1, -1, 64'h0);
        checkWrites("recover", 4, 8'd5, 8'd7, 8'd13, 8'd15);
        checkOutput("recover_done_cycle", done_rel, 29);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
